qspi_flash_ctrl: RTL and testbench
==================================

Name: qspi_flash_ctrl

Overview:
- Quad-SPI read controller with a two-requester arbiter.
- Shares one external QSPI flash between the instruction-fetch port (i_*) and the data-load port (d_*).
- Runs quad-I/O fast-read transactions: 0xEB instruction, 32-bit address, mode, dummy cycles, then a 32-bit word.
- Sits between the core's memory interfaces and the flash pins; produces SCK from the system clock.

Parameters:
- CMD_QREAD, 8'hEB: instruction byte, shifted MSB-first on dq[0].
- MODE_BYTE, 8'h00: mode byte, two nibbles, MSB nibble first.
- DUMMY_CYCLES, 4: SCK periods with outputs released.
- CS_HIGH_CYCLES, 2: minimum clk cycles CS stays high between transactions (≥1).

Ports:
- clk  in  1  system clock.
- nrst  in  1  reset, asynchronous, active-low.
- clk_div  in  4  SCK half-period in clk cycles; 0 treated as 1.
- i_req  in  1  fetch request; held with i_addr until i_ready.
- i_addr  in  32  fetch byte address.
- i_ready  out  1  one-cycle pulse; rdata valid for fetch.
- d_req  in  1  data request; held with d_addr until d_ready.
- d_addr  in  32  data byte address.
- d_ready  out  1  one-cycle pulse; rdata valid for data.
- rdata  out  32  read word, little-endian: byte at addr → [7:0].
- busy  out  1  high from grant until CS returns high and the gap completes.
- flash_cs  out  1  chip select, active-low.
- flash_sck  out  1  serial clock, idles low (mode 0).
- flash_dq_o  out  4  pin drive value.
- flash_dq_oe  out  1  1 = controller drives dq.
- flash_dq_i  in  4  pin input value.

Behaviour:
- Reset values (async, nrst low): flash_cs=1, flash_sck=0, flash_dq_oe=0, flash_dq_o=0, i_ready=d_ready=0, rdata=0, busy=0, state IDLE, rr pointer favours d.
- Reset takes effect immediately, including mid-transaction; no partial ready is produced.
- States: IDLE → INST (8 SCK) → ADDR (8) → MODE (2) → DUMMY (DUMMY_CYCLES) → DATA (8) → GAP (CS_HIGH_CYCLES clk) → IDLE. Total 30 SCK periods at default DUMMY_CYCLES.
- Arbitration (IDLE only):
  - One req asserted: grant it.
  - Both asserted: grant the port not granted last; then toggle the rr pointer.
  - Grant latches the address and N = max(clk_div,1). clk_div changes mid-transaction are ignored.
- SCK timing:
  - flash_cs falls the cycle after grant (t0).
  - SCK rises at t0+N, then toggles every N clk cycles.
  - Outputs change only at SCK falling events, or at t0 for the first bit.
  - dq_i is sampled at SCK rising events.
- Drive per phase:
  - INST: dq_o={3'b0, CMD bit}, MSB first, oe=1.
  - ADDR: addr nibbles [31:28]…[3:0], oe=1.
  - MODE: MODE_BYTE nibbles, oe=1.
  - DUMMY/DATA: oe=0. oe drops at the falling edge ending MODE.
- DATA: nibble k (0..7) goes to byte k/2; even k is the high nibble.
- Completion:
  - Last rising edge at t0+(2·30−1)·N.
  - Next cycle: rdata updated, the granted port's ready pulses for 1 cycle, flash_cs=1, sck=0.
- Latency: from req in IDLE to ready = 59N+2 clk (N=1 → 61, N=3 → 179).
- GAP: CS held high for CS_HIGH_CYCLES; requests wait, and remain pending if still held.
- rdata holds its value until the next completion.
- No alignment requirement; addr is sent verbatim.
- Dropping req mid-transaction is a protocol violation. The controller still completes and pulses ready.

Decomposition:
- Shared package holds:
  - qspi_state_t enum (IDLE, INST, ADDR, MODE, DUMMY, DATA, GAP).
  - Phase-length constants (INST_CYCLES=8, ADDR_CYCLES=8, MODE_CYCLES=2, DATA_CYCLES=8).
  - Default CMD_QREAD.
- Sub-module qspi_sck_gen:
  - Half-period counter.
  - Outputs sck plus one-cycle rise/fall strobes.
  - Inputs: enable and latched N.

Test Plan:
- Single read, clk_div=1: flash bytes 0x11,0x22,0x33,0x44 at d_addr=0x0080_0000 → d_ready at cycle 61, rdata=0x4433_2211; dq[0] bits during INST = 1,1,1,0,1,0,1,1; address nibbles 0,0,8,0,0,0,0,0.
- Arbitration: i_req and d_req both asserted in IDLE from reset → d served first, then i. A second simultaneous pair → d first, then i again. No grant inside GAP.
- clk_div=3 read → SCK half-period 3 clk, ready at 179; clk_div changed to 1 mid-transaction → no effect.
- clk_div=0 → identical timing to clk_div=1 (ready at 61).
- nrst low during DATA nibble 4 → same-cycle flash_cs=1, sck=0, oe=0, no ready. After release, a new request completes normally.
- Back-to-back held i_req → CS high exactly 2 clk between transactions; oe low during DUMMY/DATA; one ready pulse per transaction.

Source files
------------

// File: rtl/qspi_flash_ctrl_pkg.sv
// Shared types, phase lengths and pin-drive helper for the quad-SPI read controller.
package qspi_flash_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INST  = 3'd1,
        ADDR  = 3'd2,
        MODE  = 3'd3,
        DUMMY = 3'd4,
        DATA  = 3'd5,
        GAP   = 3'd6
    } qspi_state_t;

    localparam logic [3:0] INST_CYCLES = 4'd8;
    localparam logic [3:0] ADDR_CYCLES = 4'd8;
    localparam logic [3:0] MODE_CYCLES = 4'd2;
    localparam logic [3:0] DATA_CYCLES = 4'd8;

    localparam logic [7:0] CMD_QREAD_DEF = 8'hEB;
    localparam logic [7:0] MODE_BYTE_DEF = 8'h00;

    function automatic logic qspi_active(input qspi_state_t st);
        return (st != IDLE) && (st != GAP);
    endfunction

    // Returns {oe, dq[3:0]} for SCK period idx of phase st.
    function automatic logic [4:0] qspi_drive(input qspi_state_t st, input logic [2:0] idx,
                                              input logic [31:0] addr, input logic [7:0] cmd,
                                              input logic [7:0] mode);
        logic [7:0]  w_c;
        logic [31:0] w_a;
        logic [7:0]  w_m;
        w_c = cmd << idx;
        w_a = addr << {idx, 2'b00};
        w_m = mode << {idx[0], 2'b00};
        case (st)
            INST:    return {1'b1, 3'b000, w_c[7]};
            ADDR:    return {1'b1, w_a[31:28]};
            MODE:    return {1'b1, w_m[7:4]};
            default: return 5'b0_0000;
        endcase
    endfunction

endpackage

// File: rtl/qspi_flash_ctrl_sck_gen.sv
// SCK generator: half-period counter producing a mode-0 clock and edge strobes.
module qspi_flash_ctrl_sck_gen (
    input  logic       clk,
    input  logic       nrst,
    input  logic       i_en,
    input  logic [3:0] i_half,
    output logic       o_sck,
    output logic       o_rise,
    output logic       o_fall
);

    logic [3:0] r_cnt;
    logic       r_sck;
    logic       w_tick;

    assign w_tick = i_en && (r_cnt == i_half - 4'd1);
    assign o_rise = w_tick && !r_sck;
    assign o_fall = w_tick && r_sck;
    assign o_sck  = r_sck;

    // Disabling returns SCK low immediately so CS can rise with a clean idle clock.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= 4'd0;
            r_sck <= 1'b0;
        end else if (!i_en) begin
            r_cnt <= 4'd0;
            r_sck <= 1'b0;
        end else if (w_tick) begin
            r_cnt <= 4'd0;
            r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/qspi_flash_ctrl.sv
// Quad-SPI fast-read controller shared by a fetch port and a data port via round-robin.
module qspi_flash_ctrl
    import qspi_flash_ctrl_pkg::*;
#(
    parameter logic [7:0] CMD_QREAD      = CMD_QREAD_DEF,
    parameter logic [7:0] MODE_BYTE      = MODE_BYTE_DEF,
    parameter int         DUMMY_CYCLES   = 4,
    parameter int         CS_HIGH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [3:0]  clk_div,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_ready,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        flash_cs,
    output logic        flash_sck,
    output logic [3:0]  flash_dq_o,
    output logic        flash_dq_oe,
    input  logic [3:0]  flash_dq_i,
    output logic [2:0]  dbg_state
);

    localparam logic [3:0] DUMMY_LEN = 4'(DUMMY_CYCLES);
    localparam logic [7:0] GAP_LAST  = 8'(CS_HIGH_CYCLES - 2);

    qspi_state_t r_state, w_nstate, w_phase_next;
    logic [3:0]  r_cnt, w_ncnt, w_plen;
    logic        r_done, w_ndone;
    logic [7:0]  r_gap, w_ngap;
    logic        r_gnt_d, w_gnt_d;
    logic        r_rr_d;
    logic        w_grant, w_complete;
    logic [31:0] r_addr, w_addr;
    logic [3:0]  r_n, w_n;
    logic [31:0] r_sh, r_rdata;
    logic        r_i_ready, r_d_ready, r_cs, r_oe;
    logic [3:0]  r_dq_o;
    logic [4:0]  w_drive;
    logic        w_sck, w_rise, w_fall, w_sck_en;

    assign w_n      = (clk_div == 4'd0) ? 4'd1 : clk_div;
    assign w_sck_en = qspi_active(r_state) && !r_done;

    qspi_flash_ctrl_sck_gen u_sck_gen (
        .clk    (clk),
        .nrst   (nrst),
        .i_en   (w_sck_en),
        .i_half (r_n),
        .o_sck  (w_sck),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_comb begin
        w_plen       = 4'd1;
        w_phase_next = IDLE;
        case (r_state)
            INST:    begin w_plen = INST_CYCLES; w_phase_next = ADDR;  end
            ADDR:    begin w_plen = ADDR_CYCLES; w_phase_next = MODE;  end
            MODE:    begin w_plen = MODE_CYCLES; w_phase_next = DUMMY; end
            DUMMY:   begin w_plen = DUMMY_LEN;   w_phase_next = DATA;  end
            DATA:    begin w_plen = DATA_CYCLES; w_phase_next = DATA;  end
            default: begin w_plen = 4'd1;        w_phase_next = IDLE;  end
        endcase
    end

    always_comb begin
        w_nstate   = r_state;
        w_ncnt     = r_cnt;
        w_ndone    = r_done;
        w_ngap     = r_gap;
        w_gnt_d    = r_gnt_d;
        w_addr     = r_addr;
        w_grant    = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req || d_req) begin
                    w_grant  = 1'b1;
                    w_gnt_d  = d_req && (!i_req || r_rr_d);
                    w_addr   = w_gnt_d ? d_addr : i_addr;
                    w_nstate = INST;
                    w_ncnt   = 4'd0;
                end
            end
            GAP: begin
                if (r_gap >= GAP_LAST) w_nstate = IDLE;
                else                   w_ngap   = r_gap + 8'd1;
            end
            default: begin
                // The last data nibble is taken on a rising edge; completion follows one clk later.
                if (r_done) begin
                    w_complete = 1'b1;
                    w_ndone    = 1'b0;
                    w_ngap     = 8'd0;
                    w_nstate   = (CS_HIGH_CYCLES > 1) ? GAP : IDLE;
                end else if (w_rise && (r_state == DATA) && (r_cnt == DATA_CYCLES - 4'd1)) begin
                    w_ndone = 1'b1;
                end else if (w_fall) begin
                    if (r_cnt == w_plen - 4'd1) begin
                        w_nstate = w_phase_next;
                        w_ncnt   = 4'd0;
                    end else begin
                        w_ncnt = r_cnt + 4'd1;
                    end
                end
            end
        endcase
        w_drive = qspi_drive(w_nstate, w_ncnt[2:0], w_addr, CMD_QREAD, MODE_BYTE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_done  <= 1'b0;
            r_gap   <= 8'd0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_done  <= w_ndone;
            r_gap   <= w_ngap;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_addr    <= 32'd0;
            r_n       <= 4'd1;
            r_gnt_d   <= 1'b0;
            r_rr_d    <= 1'b1;
            r_sh      <= 32'd0;
            r_rdata   <= 32'd0;
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            r_cs      <= 1'b1;
            r_oe      <= 1'b0;
            r_dq_o    <= 4'd0;
        end else begin
            if (w_grant) begin
                r_addr  <= w_addr;
                r_n     <= w_n;
                r_gnt_d <= w_gnt_d;
                r_rr_d  <= !w_gnt_d;
            end
            if (w_rise && (r_state == DATA)) r_sh <= {r_sh[27:0], flash_dq_i};
            // Nibble stream is byte0 first; reorder so byte at addr lands in [7:0].
            if (w_complete) r_rdata <= {r_sh[7:0], r_sh[15:8], r_sh[23:16], r_sh[31:24]};
            r_i_ready <= w_complete && !r_gnt_d;
            r_d_ready <= w_complete && r_gnt_d;
            r_cs      <= !qspi_active(w_nstate);
            r_oe      <= w_drive[4];
            r_dq_o    <= w_drive[3:0];
        end
    end

    assign i_ready     = r_i_ready;
    assign d_ready     = r_d_ready;
    assign rdata       = r_rdata;
    assign busy        = (r_state != IDLE);
    assign flash_cs    = r_cs;
    assign flash_sck   = w_sck;
    assign flash_dq_o  = r_dq_o;
    assign flash_dq_oe = r_oe;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_qspi_flash_ctrl.sv
// Bench for qspi_flash_ctrl: pin-level flash model, scoreboard of expected words, timing checks.
module tb_qspi_flash_ctrl;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [3:0]  clk_div = 4'd1;
    logic        i_req = 1'b0, d_req = 1'b0;
    logic [31:0] i_addr = 32'd0, d_addr = 32'd0;
    logic        i_ready, d_ready, busy, flash_cs, flash_sck, flash_dq_oe;
    logic [31:0] rdata;
    logic [3:0]  flash_dq_o;
    logic [3:0]  flash_dq_i = 4'd0;
    logic [2:0]  dbg_state;

    qspi_flash_ctrl dut (
        .clk(clk), .nrst(nrst), .clk_div(clk_div),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready),
        .d_req(d_req), .d_addr(d_addr), .d_ready(d_ready),
        .rdata(rdata), .busy(busy),
        .flash_cs(flash_cs), .flash_sck(flash_sck),
        .flash_dq_o(flash_dq_o), .flash_dq_oe(flash_dq_oe), .flash_dq_i(flash_dq_i),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Flash contents: explicit bytes where written, otherwise a fixed hash of the address.
    logic [7:0] mem [logic [31:0]];
    function automatic logic [7:0] flash_byte(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endfunction
    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return {flash_byte(a + 32'd3), flash_byte(a + 32'd2), flash_byte(a + 32'd1), flash_byte(a)};
    endfunction

    logic [31:0] exp_q[$];

    // Pin-level flash: decodes what the controller sends and returns data on SCK falls.
    int          rc = 0, oe_bad = 0;
    int          t0_cyc = 0, first_rise = 0, last_rise = 0, cs_up_cyc = 0, last_gap = 0;
    logic [7:0]  cap_cmd = 8'd0, cap_mode = 8'd0;
    logic [31:0] cap_addr = 32'd0;

    always @(posedge flash_cs) cs_up_cyc = cyc;
    always @(negedge flash_cs) begin
        last_gap = cyc - cs_up_cyc;
        t0_cyc   = cyc;
        rc       = 0;
        oe_bad   = 0;
        cap_cmd  = 8'd0;
        cap_addr = 32'd0;
        cap_mode = 8'd0;
    end
    always @(posedge flash_sck) begin
        if (!flash_cs) begin
            if (rc == 0) first_rise = cyc;
            last_rise = cyc;
            if (rc < 8) begin
                cap_cmd = {cap_cmd[6:0], flash_dq_o[0]};
                if (flash_dq_o[3:1] != 3'b000) oe_bad++;
            end else if (rc < 16) begin
                cap_addr = {cap_addr[27:0], flash_dq_o};
            end else if (rc < 18) begin
                cap_mode = {cap_mode[3:0], flash_dq_o};
            end
            if ((rc < 18) != (flash_dq_oe === 1'b1)) oe_bad++;
            rc++;
        end
    end
    always @(negedge flash_sck) begin : flash_out
        int k;
        logic [7:0] b;
        if (!flash_cs && rc >= 22 && rc < 30) begin
            k = rc - 22;
            b = flash_byte(cap_addr + 32'(k >> 1));
            flash_dq_i = (k % 2 == 0) ? b[7:4] : b[3:0];
        end
    end

    task automatic wait_ready(output bit got_d, output int lat);
        got_d = 1'b0;
        lat   = 0;
        for (int c = 1; c <= 4000; c++) begin
            @(posedge clk);
            #1;
            if (i_ready || d_ready) begin
                lat   = c;
                got_d = d_ready;
                return;
            end
        end
        chk("ready_timeout", 64'd1, 64'd0);
    endtask

    task automatic check_txn(input bit exp_d, input logic [31:0] a, input int n,
                             input bit got_d, input int lat, input int exp_lat);
        logic [31:0] w;
        w = 32'd0;
        if (exp_q.size() > 0) w = exp_q.pop_front();
        chk("port_d", 64'(got_d), 64'(exp_d));
        chk("rdata", 64'(rdata), 64'(w));
        chk("cmd", 64'(cap_cmd), 64'h00EB);
        chk("addr", 64'(cap_addr), 64'(a));
        chk("mode", 64'(cap_mode), 64'h0);
        chk("oe_pattern", 64'(oe_bad), 64'd0);
        chk("sck_rises", 64'(rc), 64'd30);
        chk("sck_first", 64'(first_rise - t0_cyc), 64'(n));
        chk("sck_span", 64'(last_rise - first_rise), 64'(58 * n));
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("cs_end", 64'(flash_cs), 64'd1);
        chk("sck_end", 64'(flash_sck), 64'd0);
        chk("busy_end", 64'(busy), 64'd1);
    endtask

    task automatic idle(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic do_read(input bit use_d, input logic [31:0] a, input logic [3:0] div,
                           input int change_after);
        bit got_d;
        int lat, n;
        n = (div == 4'd0) ? 1 : int'(div);
        clk_div = div;
        exp_q.push_back(exp_word(a));
        if (use_d) begin d_addr = a; d_req = 1'b1; end
        else       begin i_addr = a; i_req = 1'b1; end
        if (change_after > 0) begin
            idle(change_after);
            clk_div = 4'd1;
        end
        wait_ready(got_d, lat);
        lat += change_after;
        d_req = 1'b0;
        i_req = 1'b0;
        check_txn(use_d, a, n, got_d, lat, 59 * n + 2);
        idle(1);
        chk("ready_pulse", 64'({i_ready, d_ready}), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
        idle(2);
    endtask

    initial begin
        bit got_d;
        int lat;
        logic [31:0] a_i, a_d, a;
        int c;

        idle(3);
        chk("rst_cs", 64'(flash_cs), 64'd1);
        chk("rst_sck", 64'(flash_sck), 64'd0);
        chk("rst_oe", 64'(flash_dq_oe), 64'd0);
        chk("rst_dq", 64'(flash_dq_o), 64'd0);
        chk("rst_ready", 64'({i_ready, d_ready}), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        nrst = 1'b1;
        idle(2);

        // Simultaneous requests: d wins first each time, i follows after the CS gap.
        for (int p = 0; p < 2; p++) begin
            a_i = $urandom;
            a_d = $urandom;
            clk_div = 4'd1;
            exp_q.push_back(exp_word(a_d));
            exp_q.push_back(exp_word(a_i));
            i_addr = a_i; d_addr = a_d;
            i_req = 1'b1; d_req = 1'b1;
            wait_ready(got_d, lat);
            d_req = 1'b0;
            check_txn(1'b1, a_d, 1, got_d, lat, 61);
            wait_ready(got_d, lat);
            i_req = 1'b0;
            check_txn(1'b0, a_i, 1, got_d, lat, 62);
            chk("arb_gap", 64'(last_gap), 64'd2);
            idle(3);
        end

        mem[32'h0080_0000] = 8'h11;
        mem[32'h0080_0001] = 8'h22;
        mem[32'h0080_0002] = 8'h33;
        mem[32'h0080_0003] = 8'h44;
        do_read(1'b1, 32'h0080_0000, 4'd1, 0);
        chk("plan_word", 64'(rdata), 64'h4433_2211);

        do_read(1'b0, $urandom, 4'd3, 40);
        do_read(1'b0, $urandom, 4'd0, 0);

        // Held fetch request: two back-to-back transactions.
        a = $urandom;
        clk_div = 4'd2;
        exp_q.push_back(exp_word(a));
        exp_q.push_back(exp_word(a));
        i_addr = a;
        i_req = 1'b1;
        wait_ready(got_d, lat);
        check_txn(1'b0, a, 2, got_d, lat, 120);
        wait_ready(got_d, lat);
        i_req = 1'b0;
        check_txn(1'b0, a, 2, got_d, lat, 121);
        chk("b2b_gap", 64'(last_gap), 64'd2);
        idle(3);

        for (int r = 0; r < 8; r++) begin
            a = $urandom;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 1) == 1) mem[a + 32'(b)] = 8'($urandom);
            do_read(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 4)), 0);
        end

        // Reset in the middle of the data phase.
        clk_div = 4'd1;
        d_addr = $urandom;
        d_req = 1'b1;
        c = 0;
        while (!(rc >= 26 && !flash_cs) && c < 300) begin
            idle(1);
            c++;
        end
        chk("mid_reached", 64'(c < 300), 64'd1);
        #2;
        nrst = 1'b0;
        #1;
        chk("mid_cs", 64'(flash_cs), 64'd1);
        chk("mid_sck", 64'(flash_sck), 64'd0);
        chk("mid_oe", 64'(flash_dq_oe), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_rdata", 64'(rdata), 64'd0);
        d_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chk("mid_no_ready", 64'({i_ready, d_ready}), 64'd0);
        end
        nrst = 1'b1;
        idle(2);
        do_read(1'b1, $urandom, 4'd1, 0);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
